// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line-refill interface.
// Accepts whole-line read/write requests, answers after a fixed latency
// with a one-cycle ready pulse, and counts completed reads and writes.
module mem_line_responder #(
  parameter int LINE_BITS  = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_req_valid_i,
  input  logic                 mem_req_rw_i,
  input  logic [31:0]          mem_req_addr_i,
  input  logic [LINE_BITS-1:0] mem_req_data_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_ready_o,
  output logic [31:0]          no_rd_o,
  output logic [31:0]          no_wr_o
);

  // Byte offset bits inside one line; these never select a line.
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [LINE_BITS-1:0]    wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic [LINE_BITS-1:0]    mem_data_q;
  logic [31:0]             no_rd_q, no_rd_d;
  logic [31:0]             no_wr_q, no_wr_d;
  logic                    enter_resp;

  // Line storage; not cleared by reset.
  logic [LINE_BITS-1:0]    mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    unused_addr_bits;

  // Index bits only; offset bits and bits above the index alias freely.
  assign req_idx          = mem_req_addr_i[OFF+DEPTH_LOG2-1:OFF];
  assign unused_addr_bits = ^{mem_req_addr_i[31:OFF+DEPTH_LOG2], mem_req_addr_i[OFF-1:0]};

  // Next-state logic: latch the request in IDLE, count down in BUSY, pulse in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid_i) begin
          rw_d    = mem_req_rw_i;
          idx_d   = req_idx;
          wdata_d = mem_req_data_i;
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Ready, read data and counters are registered so they all change together
  // on the edge that enters RESP; rw_d/idx_d are the request being completed.
  assign enter_resp = (state_d == RESP);

  // Completion bookkeeping for the request that is about to respond.
  always_comb begin
    ready_d = enter_resp;
    no_rd_d = no_rd_q;
    no_wr_d = no_wr_q;
    if (enter_resp) begin
      if (rw_d) no_wr_d = no_wr_q + 32'd1;
      else      no_rd_d = no_rd_q + 32'd1;
    end
  end

  // State, request latches, outputs and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rw_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      mem_data_q <= '0;
      no_rd_q    <= 32'd0;
      no_wr_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      no_rd_q <= no_rd_d;
      no_wr_q <= no_wr_d;
      if (enter_resp && !rw_d) begin
        mem_data_q <= mem_q[idx_d];
      end
    end
  end

  // Write the latched line at the end of the RESP cycle unless reset intervenes.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == RESP && rw_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_data_o  = mem_data_q;
  assign mem_ready_o = ready_q;
  assign no_rd_o     = no_rd_q;
  assign no_wr_o     = no_wr_q;

endmodule
